// File: rtl/uart_debug_monitor.sv
// UART debug monitor: escape-key decode, run/halt/step control, status text and echo into a tx FIFO.
// Latency: control outputs one cycle after the rx byte, first message byte written the cycle after that.
// Backpressure: tx_valid/tx_ready drain the FIFO; writes into a full FIFO are dropped and flagged on ovf_o.
module uart_debug_monitor #(
    parameter int NKEYS        = 12,
    parameter int FKEY_PULSE   = 1,
    parameter int TXFIFO_DEPTH = 16,
    parameter int ESC_TIMEOUT  = 240000
) (
    input  logic             clk24,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             ihex_error,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             halt_o,
    output logic             step_o,
    output logic [NKEYS-1:0] fkeys_o,
    output logic             ovf_o
);
    typedef enum logic [1:0] {M_INIT, M_RUN, M_HALT} mode_t;
    typedef enum logic [2:0] {E_IDLE, E_1, E_2, E_3, E_4} esc_t;

    localparam logic [1:0] MSG_RUN  = 2'd0;
    localparam logic [1:0] MSG_HALT = 2'd1;
    localparam logic [1:0] MSG_ERR  = 2'd2;
    localparam int TW = $clog2(ESC_TIMEOUT + 1);
    localparam int PW = $clog2(FKEY_PULSE + 1);
    localparam logic [TW-1:0] TMR_END      = TW'(ESC_TIMEOUT);
    localparam logic [PW-1:0] PULSE_RELOAD = PW'(FKEY_PULSE - 1);

    function automatic logic [7:0] msg_char(input logic [1:0] id, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h0A;
        case (id)
            MSG_RUN:  case (idx) 3'd0: c = "R"; 3'd1: c = "U"; 3'd2: c = "N"; default: c = 8'h0A; endcase
            MSG_HALT: case (idx) 3'd0: c = "H"; 3'd1: c = "A"; 3'd2: c = "L"; 3'd3: c = "T"; default: c = 8'h0A; endcase
            default:  case (idx) 3'd0: c = "E"; 3'd1: c = "R"; 3'd2: c = "R"; default: c = 8'h0A; endcase
        endcase
        return c;
    endfunction

    mode_t mode, mode_nxt;
    esc_t  esc, esc_cur, esc_nxt;
    logic [6:0]       esc_code, code_nxt;
    logic [TW-1:0]    esc_tmr;
    logic             line_start, line_start_nxt;
    logic             rx_msg_req, echo_req, step_req, key_fire, is_digit;
    logic [1:0]       rx_msg_id;
    logic [7:0]       echo_byte;
    logic [3:0]       key_idx;
    logic [NKEYS-1:0] fkey_onehot;
    logic [PW-1:0]    fkey_cnt;
    logic             err_prev, err_pend, err_take;
    logic             msg_active, msg_q_vld, msg_last, echo_vld;
    logic [1:0]       msg_id, msg_q_id, req_id;
    logic [2:0]       msg_idx;
    logic [7:0]       echo_dat;
    logic             msg_req, slot_ok, q_start, req_start, req_queue;
    logic             fifo_wr_vld, fifo_wr_rdy;
    logic [7:0]       fifo_wr_dat;

    assign is_digit = (rx_data >= "0") && (rx_data <= "9");

    always_comb begin
        mode_nxt       = mode;
        esc_cur        = esc;
        line_start_nxt = line_start;
        code_nxt       = esc_code;
        rx_msg_req     = 1'b0;
        rx_msg_id      = MSG_RUN;
        echo_req       = 1'b0;
        echo_byte      = rx_data;
        step_req       = 1'b0;
        key_fire       = 1'b0;
        key_idx        = 4'd0;
        if (esc != E_IDLE && esc_tmr == TMR_END) esc_cur = E_IDLE;
        esc_nxt = esc_cur;
        unique case (mode)
            M_INIT: begin
                mode_nxt   = M_RUN;
                rx_msg_req = 1'b1;
            end
            M_RUN: if (rx_valid) begin
                if (rx_data == 8'h03) begin
                    mode_nxt       = M_HALT;
                    esc_nxt        = E_IDLE;
                    line_start_nxt = 1'b1;
                    rx_msg_req     = 1'b1;
                    rx_msg_id      = MSG_HALT;
                end else begin
                    // Any byte that does not advance the sequence drops to IDLE, ESC restarts it.
                    esc_nxt = (rx_data == 8'h1B) ? E_1 : E_IDLE;
                    case (esc_cur)
                        E_1: if (rx_data == "[") esc_nxt = E_2;
                        E_2: if (is_digit) begin
                            esc_nxt  = E_3;
                            code_nxt = {3'b000, rx_data[3:0]};
                        end
                        E_3: if (is_digit) begin
                            esc_nxt  = E_4;
                            code_nxt = esc_code * 7'd10 + {3'b000, rx_data[3:0]};
                        end
                        E_4: if (rx_data == "~") begin
                            if (esc_code >= 7'd11 && esc_code <= 7'd15) begin
                                key_fire = 1'b1;
                                key_idx  = 4'(esc_code - 7'd11);
                            end else if (esc_code >= 7'd17 && esc_code <= 7'd21) begin
                                key_fire = 1'b1;
                                key_idx  = 4'(esc_code - 7'd12);
                            end else if (esc_code == 7'd23 || esc_code == 7'd24) begin
                                key_fire = 1'b1;
                                key_idx  = 4'(esc_code - 7'd13);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            M_HALT: if (rx_valid) begin
                if (line_start && rx_data == "c") begin
                    mode_nxt   = M_RUN;
                    rx_msg_req = 1'b1;
                end else if (line_start && rx_data == "s") begin
                    step_req = 1'b1;
                end else begin
                    echo_req       = 1'b1;
                    echo_byte      = (rx_data == 8'h0D) ? 8'h0A : rx_data;
                    line_start_nxt = (rx_data == 8'h0D) || (rx_data == 8'h0A);
                end
            end
            default: mode_nxt = M_INIT;
        endcase
    end

    always_comb begin
        fkey_onehot = '0;
        for (int k = 0; k < NKEYS; k++) fkey_onehot[k] = (key_idx == 4'(k));
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= M_INIT;
            esc        <= E_IDLE;
            esc_code   <= 7'd0;
            line_start <= 1'b0;
        end else begin
            mode       <= mode_nxt;
            esc        <= esc_nxt;
            esc_code   <= code_nxt;
            line_start <= line_start_nxt;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            esc_tmr  <= '0;
            step_o   <= 1'b0;
            fkeys_o  <= '0;
            fkey_cnt <= '0;
            err_prev <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            if (rx_valid) esc_tmr <= '0;
            else if (esc != E_IDLE && esc_tmr != TMR_END) esc_tmr <= esc_tmr + TW'(1);
            step_o <= step_req;
            // Out-of-range keys give an empty one-hot and leave any running pulse alone.
            if (key_fire && fkey_onehot != '0) begin
                fkeys_o  <= fkey_onehot;
                fkey_cnt <= PULSE_RELOAD;
            end else if (fkey_cnt != '0) begin
                fkey_cnt <= fkey_cnt - PW'(1);
            end else begin
                fkeys_o <= '0;
            end
            err_prev <= ihex_error;
            if (mode == M_HALT && ihex_error && !err_prev) err_pend <= 1'b1;
            else if (err_take) err_pend <= 1'b0;
        end
    end

    // One active message, one queued behind it; pending echo goes out before the queued one starts.
    assign msg_req   = rx_msg_req | err_pend;
    assign req_id    = rx_msg_req ? rx_msg_id : MSG_ERR;
    assign q_start   = msg_q_vld && !msg_active && !echo_vld;
    assign slot_ok   = !msg_q_vld || q_start;
    assign err_take  = err_pend && !rx_msg_req && slot_ok;
    assign req_start = msg_req && slot_ok && !msg_active && !msg_q_vld;
    assign req_queue = msg_req && slot_ok && !req_start;
    assign msg_last  = msg_active && (msg_idx == ((msg_id == MSG_HALT) ? 3'd4 : 3'd3));

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            msg_active <= 1'b0;
            msg_id     <= MSG_RUN;
            msg_idx    <= 3'd0;
            msg_q_vld  <= 1'b0;
            msg_q_id   <= MSG_RUN;
            echo_vld   <= 1'b0;
            echo_dat   <= 8'h00;
            ovf_o      <= 1'b0;
        end else begin
            if (q_start) begin
                msg_active <= 1'b1;
                msg_id     <= msg_q_id;
                msg_idx    <= 3'd0;
            end else if (req_start) begin
                msg_active <= 1'b1;
                msg_id     <= req_id;
                msg_idx    <= 3'd0;
            end else if (msg_active) begin
                msg_idx <= msg_idx + 3'd1;
                if (msg_last) msg_active <= 1'b0;
            end
            if (req_queue) begin
                msg_q_vld <= 1'b1;
                msg_q_id  <= req_id;
            end else if (q_start) begin
                msg_q_vld <= 1'b0;
            end
            if (echo_req) begin
                echo_vld <= 1'b1;
                echo_dat <= echo_byte;
            end else if (!msg_active) begin
                echo_vld <= 1'b0;
            end
            if (fifo_wr_vld && !fifo_wr_rdy) ovf_o <= 1'b1;
        end
    end

    assign fifo_wr_vld = msg_active | echo_vld;
    assign fifo_wr_dat = msg_active ? msg_char(msg_id, msg_idx) : echo_dat;
    assign halt_o      = (mode == M_HALT);

    fifo #(.W(8), .DEPTH(TXFIFO_DEPTH)) u_txfifo (
        .clk    (clk24),
        .rst_n  (rst_n),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (tx_valid),
        .rd_dat (tx_data),
        .rd_rdy (tx_ready)
    );
endmodule

// Generic synchronous FIFO, power-of-two depth, extra pointer bit distinguishes full from empty.
// Latency: written data visible at rd_dat the cycle after the write.
// Backpressure: wr_rdy low when full unless the same cycle pops; rd_vld whenever not empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         empty, full, do_wr, do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = rd_rdy && !empty;
    assign wr_rdy = !full || rd_rdy;
    assign do_wr  = wr_vld && wr_rdy;
    assign rd_vld = !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule
